fifo_sm: RTL and testbench
==========================

// Module: fifo_sm
// PURPOSE
//  Multi-stream merge FIFO, the many-writers/one-reader counterpart of fifo_ms.
//  FLUX independent producers each push untagged words into a private lane.
//  A single consumer pops tagged words {lane_id, data} in round-robin lane order.
//  Sits upstream of any block that consumes the tagged stream format produced by fifo_ms.
// PARAMETERS
//  DATA_WIDTH  32  payload bits per word
//  DEPTH       8   words per lane; DEPTH >= 2, need not be a power of two
//  FLUX        4   number of input lanes; FLUX >= 2
//  TAG_W       $clog2(FLUX)  localparam, lane-id width
// PORTS
//  clk    in   1                   single clock; all state on posedge clk
//  rst    in   1                   asynchronous, active-low reset
//  din    in   FLUX*DATA_WIDTH     lane i payload at din[i*DATA_WIDTH +: DATA_WIDTH]
//  write  in   FLUX                per-lane push strobe
//  full   out  FLUX                per-lane full, registered (count == DEPTH)
//  dout   out  TAG_W+DATA_WIDTH    {lane_id, data} of the current head; show-ahead
//  read   in   1                   pop strobe for dout
//  empty  out  1                   1 when every lane is empty
// BEHAVIOUR
//  Reset (rst == 0, async):
//   - all lane pointers and counts are cleared, and the rr pointer is cleared to 0.
//   - full = 0, empty = 1, dout = 0. Stored contents are discarded.
//   - Reset mid-burst takes effect immediately. An in-flight write or read in that cycle is lost.
//  Lanes:
//   - Each lane is a circular buffer with wr_ptr, rd_ptr and count (0..DEPTH).
//   - Pointers wrap from DEPTH-1 to 0.
//   - A push happens when write[i] && !full[i]. A write while full is dropped silently,
//     even if the same lane is popped in that cycle.
//   - Push and pop on the same lane in the same cycle leave count unchanged and preserve order.
//  Arbitration:
//   - rr_ptr (TAG_W bits) is registered.
//   - sel is a combinational pick: the first lane with count != 0, scanning rr_ptr, rr_ptr+1, ...
//     with the scan index taken mod FLUX.
//   - sel depends only on registered state, so dout is stable for the whole cycle.
//   - empty = (all counts == 0).
//   - dout = {sel, head[sel]} when !empty, else 0.
//   - Pop happens when read && !empty. It pops lane sel and sets rr_ptr <= (sel+1) mod FLUX.
//   - A read while empty is ignored; no state changes.
//   - rr_ptr holds when there is no pop.
//  Latency and fairness:
//   - A word pushed at edge N is visible on dout after edge N (earliest pop at edge N+1),
//     provided its lane is selected.
//   - Per-lane order is strictly FIFO.
//   - A non-empty lane waits at most FLUX-1 pops before being served.
//  Full flag: full[i] rises the cycle after the DEPTH-th push and falls the cycle after a pop frees a slot.
//  The tag is the lane index in binary. With non-power-of-two FLUX, tag values >= FLUX never appear.
// STRUCTURE
//  Shared package fifo_pkg:
//   - function tag_w(flux) returning $clog2(flux).
//   - typedef of the tagged word struct {tag, data} used on dout.
//   - lane_t count type sized $clog2(DEPTH+1).
//  Sub-module fifo_lane (DATA_WIDTH, DEPTH), generated FLUX times:
//   - inputs clk, rst, din, push, pop.
//   - outputs head, count, full.
//   - single-lane circular buffer, show-ahead.
//  The round-robin pick, dout mux and rr_ptr are inline in fifo_sm.
// TESTING
//  1 Assert rst=0 mid-run, release -> full=4'b0000, empty=1, dout=0; read pulses change nothing.
//  2 write=4'b0100, lane2 din=32'hA5 -> next cycle empty=0, dout={2'd2,32'h000000A5};
//    read -> empty=1 the following cycle.
//  3 Push 9 words 1..9 into lane0 with no reads -> full[0]=1 after the 8th;
//    8 pops return 1..8, the 9th word never appears, then empty=1.
//  4 Lanes 0,1,3 each preloaded with 2 words, read held high
//    -> tag sequence 0,1,3,0,1,3, then empty=1; lane2 never selected.
//  5 Lane1 count=1, push 32'h11 and pop in the same cycle -> count stays 1, next dout = 32'h11.
//    Lane1 full, push+pop together -> pushed word dropped, full[1]=0 next cycle.
//  6 Async rst=0 asserted between edges during a 4-lane burst
//    -> empty=1 and full=0 immediately; after release the first push is the first word read.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths, count and tagged-word types for the stream FIFOs
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_FLUX       = 4;

    function automatic int tag_w(input int flux);
        return $clog2(flux);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEF_TAG_W = tag_w(DEF_FLUX);

    typedef logic [cnt_w(DEF_DEPTH)-1:0] lane_t;

    typedef struct packed {
        logic [DEF_TAG_W-1:0]      tag;
        logic [DEF_DATA_WIDTH-1:0] data;
    } tagged_t;

endpackage

// File: rtl/fifo_lane.sv
// rtl/fifo_lane.sv - single-lane show-ahead circular buffer with registered full flag
module fifo_lane
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    localparam int CW        = cnt_w(DEPTH),
    localparam int PW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  push,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CW-1:0]         count,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count_next;
    logic                  do_push, do_pop;

    // A write into a full lane is dropped even when the lane is popped this cycle.
    assign do_push    = push && !full;
    assign do_pop     = pop && (count != '0);
    assign count_next = count + CW'(do_push) - CW'(do_pop);
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fifo_sm.sv
// rtl/fifo_sm.sv - many-writer merge FIFO: per-lane buffers, round-robin tagged read port
module fifo_sm
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int FLUX       = 4,
    localparam int TAG_W     = tag_w(FLUX),
    localparam int CW        = cnt_w(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FLUX*DATA_WIDTH-1:0] din,
    input  logic [FLUX-1:0]            write,
    output logic [FLUX-1:0]            full,
    output logic [TAG_W+DATA_WIDTH-1:0] dout,
    input  logic                       read,
    output logic                       empty
);

    logic [DATA_WIDTH-1:0] heads [FLUX];
    logic [CW-1:0]         counts [FLUX];
    logic [FLUX-1:0]       nonempty;
    logic [FLUX-1:0]       pops;
    logic [TAG_W-1:0]      rr_ptr;
    logic [TAG_W-1:0]      sel;
    logic                  do_pop;

    for (genvar gi = 0; gi < FLUX; gi++) begin : g_lane
        fifo_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .din   (din[gi*DATA_WIDTH +: DATA_WIDTH]),
            .push  (write[gi]),
            .pop   (pops[gi]),
            .head  (heads[gi]),
            .count (counts[gi]),
            .full  (full[gi])
        );
        assign nonempty[gi] = (counts[gi] != '0);
        assign pops[gi]     = do_pop && (sel == TAG_W'(gi));
    end

    assign empty  = ~|nonempty;
    assign do_pop = read && !empty;

    // Scan starts at rr_ptr so the lane after the last one served gets first claim.
    always_comb begin
        logic found;
        int   idx;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < FLUX; k++) begin
            idx = (int'(rr_ptr) + k) % FLUX;
            if (!found && nonempty[idx]) begin
                sel   = TAG_W'(idx);
                found = 1'b1;
            end
        end
    end

    assign dout = empty ? '0 : {sel, heads[sel]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_ptr <= '0;
        else if (do_pop)
            rr_ptr <= (sel == TAG_W'(FLUX - 1)) ? '0 : sel + 1'b1;
    end

endmodule

// File: tb/tb_fifo_sm.sv
// tb/tb_fifo_sm.sv - randomized and directed bench for fifo_sm against a queue model
module tb_fifo_sm;
    import fifo_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int FLUX  = 4;
    localparam int TW    = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [FLUX*DW-1:0]    din = '0;
    logic [FLUX-1:0]       write = '0;
    logic                  read = 1'b0;
    logic [FLUX-1:0]       full;
    logic [TW+DW-1:0]      dout;
    logic                  empty;

    fifo_sm #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FLUX(FLUX)) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .write (write),
        .full  (full),
        .dout  (dout),
        .read  (read),
        .empty (empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq [FLUX][$];
    int            rr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int m_sel();
        for (int k = 0; k < FLUX; k++)
            if (mq[(rr + k) % FLUX].size() != 0)
                return (rr + k) % FLUX;
        return -1;
    endfunction

    task automatic check_all(input string tag);
        int              s;
        logic [TW+DW-1:0] ed;
        logic [FLUX-1:0]  ef;
        s  = m_sel();
        ed = '0;
        if (s >= 0)
            ed = {TW'(s), mq[s][0]};
        for (int i = 0; i < FLUX; i++)
            ef[i] = (mq[i].size() == DEPTH);
        check({tag, "_empty"}, 64'(empty), 64'(s < 0));
        check({tag, "_full"},  64'(full),  64'(ef));
        check({tag, "_dout"},  64'(dout),  64'(ed));
    endtask

    task automatic model_reset();
        for (int i = 0; i < FLUX; i++)
            mq[i].delete();
        rr = 0;
    endtask

    task automatic model_update();
        int sz [FLUX];
        int s;
        for (int i = 0; i < FLUX; i++)
            sz[i] = mq[i].size();
        s = m_sel();
        if (read && s >= 0) begin
            void'(mq[s].pop_front());
            rr = (s + 1) % FLUX;
        end
        for (int i = 0; i < FLUX; i++)
            if (write[i] && sz[i] < DEPTH)
                mq[i].push_back(din[i*DW +: DW]);
    endtask

    task automatic tick(input string tag);
        model_update();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        write = '0;
        read  = 1'b0;
        din   = '0;
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic reset_pulse(input string tag);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        check_all({tag, "_hold"});
        rst = 1'b1;
    endtask

    task automatic rand_din();
        for (int i = 0; i < FLUX; i++)
            din[i*DW +: DW] = $urandom;
    endtask

    int exp_tags [6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        // 1: reset state, mid-run reset, reads while empty
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_all("t1_reset");
        rst = 1'b1;
        write = 4'b1111;
        rand_din();
        tick("t1_fill");
        tick("t1_fill");
        idle();
        reset_pulse("t1_midrst");
        read = 1'b1;
        repeat (3) tick("t1_rd_empty");
        check("t1_empty_const", 64'(empty), 64'd1);
        read = 1'b0;

        // 2: single word on lane 2
        din[2*DW +: DW] = 32'hA5;
        write = 4'b0100;
        tick("t2_push");
        idle();
        check("t2_dout", 64'(dout), 64'({2'd2, 32'h0000_00A5}));
        check("t2_notempty", 64'(empty), 64'd0);
        read = 1'b1;
        tick("t2_pop");
        read = 1'b0;
        check("t2_empty", 64'(empty), 64'd1);

        // 3: overfill lane 0, ninth word is dropped
        for (int i = 1; i <= 9; i++) begin
            din[0 +: DW] = 32'(i);
            write = 4'b0001;
            tick("t3_push");
            if (i == 8)
                check("t3_full8", 64'(full[0]), 64'd1);
        end
        idle();
        for (int i = 1; i <= 8; i++) begin
            check("t3_data", 64'(dout), 64'({2'd0, 32'(i)}));
            read = 1'b1;
            tick("t3_pop");
            read = 1'b0;
        end
        check("t3_empty", 64'(empty), 64'd1);

        // 4: round-robin skips the idle lane
        reset_pulse("t4_rst");
        write = 4'b1011;
        rand_din();
        tick("t4_load");
        rand_din();
        tick("t4_load");
        idle();
        read = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("t4_tag", 64'(dout[DW +: TW]), 64'(exp_tags[k]));
            tick("t4_pop");
        end
        read = 1'b0;
        check("t4_empty", 64'(empty), 64'd1);

        // 5: simultaneous push/pop on one lane, then on a full lane
        reset_pulse("t5_rst");
        din[DW +: DW] = 32'h22;
        write = 4'b0010;
        tick("t5_pre");
        din[DW +: DW] = 32'h11;
        read = 1'b1;
        tick("t5_pushpop");
        idle();
        check("t5_dout", 64'(dout), 64'({2'd1, 32'h11}));
        read = 1'b1;
        tick("t5_drain");
        read = 1'b0;
        check("t5_empty", 64'(empty), 64'd1);
        write = 4'b0010;
        for (int i = 0; i < DEPTH; i++) begin
            din[DW +: DW] = 32'h100 + 32'(i);
            tick("t5_fill");
        end
        check("t5_full", 64'(full[1]), 64'd1);
        din[DW +: DW] = 32'hDEAD;
        read = 1'b1;
        tick("t5_fullpp");
        idle();
        check("t5_unfull", 64'(full[1]), 64'd0);
        for (int i = 1; i < DEPTH; i++) begin
            check("t5_order", 64'(dout), 64'({2'd1, 32'h100 + 32'(i)}));
            read = 1'b1;
            tick("t5_drain");
            read = 1'b0;
        end
        check("t5_empty2", 64'(empty), 64'd1);

        // 6: async reset during a four-lane burst
        write = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            rand_din();
            read = 1'($urandom_range(0, 1));
            tick("t6_burst");
        end
        idle();
        reset_pulse("t6_rst");
        check("t6_empty", 64'(empty), 64'd1);
        din[2*DW +: DW] = 32'h77;
        write = 4'b0100;
        tick("t6_first");
        idle();
        check("t6_firstword", 64'(dout), 64'({2'd2, 32'h77}));

        // random traffic, light then heavy read load
        for (int c = 0; c < 3000; c++) begin
            rand_din();
            write = 4'($urandom);
            if (c < 1500)
                read = ($urandom_range(0, 3) == 0);
            else
                read = ($urandom_range(0, 3) != 0);
            tick("rand");
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
